// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Clock cycles per digit slot.
  function automatic int tick_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot phase counter: ph walks 0..TICK_DIV-1 and flags the blank and slot ends.
module scan_prescaler #(
  parameter int TICK_DIV  = 10,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic slot_end,
  output logic blank_end
);

  localparam int PH_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PH_W-1:0] ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
    end else if (clear) begin
      ph <= '0;
    end else if (enable) begin
      ph <= slot_end ? '0 : ph + PH_W'(1);
    end
  end

  assign slot_end  = enable && (ph == PH_W'(TICK_DIV - 1));
  assign blank_end = enable && (ph == PH_W'(BLANK_CYC - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit slots with a leading blank,
// and display words committed only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int N_DIG     = 4,
  parameter int DIG_W     = 4,
  parameter int BLANK_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load_valid,
  input  logic [N_DIG*DIG_W-1:0]     load_data,
  output logic                       load_ready,
  output logic [N_DIG-1:0]           an_n,
  output logic [$clog2(N_DIG)-1:0]   dig_sel,
  output logic [DIG_W-1:0]           dig_val,
  output logic                       frame_done
);

  localparam int TICK_DIV = tick_div(CLK_HZ, SCAN_HZ);
  localparam int SEL_W    = $clog2(N_DIG);
  localparam int WORD_W   = N_DIG * DIG_W;

  scan_state_t       state;
  logic [WORD_W-1:0] active;
  logic [WORD_W-1:0] pending;
  logic              pend;
  logic              slot_end;
  logic              blank_end;
  logic              wrap;
  logic              commit;
  logic              accept;
  logic [WORD_W-1:0] next_active;
  logic [SEL_W-1:0]  sel_inc;

  function automatic logic [DIG_W-1:0] digit_of(input logic [WORD_W-1:0] w,
                                                 input logic [SEL_W-1:0]  s);
    return w[s*DIG_W +: DIG_W];
  endfunction

  function automatic logic [N_DIG-1:0] anode_dec(input logic [SEL_W-1:0] s);
    logic [N_DIG-1:0] r;
    for (int i = 0; i < N_DIG; i++) begin
      r[i] = (s != SEL_W'(i));
    end
    return r;
  endfunction

  scan_prescaler #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clear     (!en || state == IDLE),
    .enable    (state != IDLE),
    .slot_end  (slot_end),
    .blank_end (blank_end)
  );

  // A frame ends when the last digit's SHOW slot expires while still enabled.
  assign wrap        = en && (state == SHOW) && slot_end && (dig_sel == SEL_W'(N_DIG - 1));
  assign commit      = pend && (wrap || state == IDLE);
  assign accept      = load_valid && load_ready;
  assign next_active = commit ? pending : active;
  assign sel_inc     = wrap ? '0 : dig_sel + SEL_W'(1);

  // Word buffering: accept and commit are exclusive because load_ready == !pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active     <= '0;
      pending    <= '0;
      pend       <= 1'b0;
      load_ready <= 1'b1;
    end else if (commit) begin
      active     <= pending;
      pend       <= 1'b0;
      load_ready <= 1'b1;
    end else if (accept) begin
      pending    <= load_data;
      pend       <= 1'b1;
      load_ready <= 1'b0;
    end
  end

  // Scan FSM; an_n is decoded from the state being entered so it stays registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      an_n       <= '1;
      dig_sel    <= '0;
      dig_val    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state <= IDLE;
        an_n  <= '1;
      end else begin
        case (state)
          IDLE: begin
            state   <= BLANK;
            an_n    <= '1;
            dig_sel <= '0;
            dig_val <= next_active[DIG_W-1:0];
          end
          BLANK: begin
            if (blank_end) begin
              state <= SHOW;
              an_n  <= anode_dec(dig_sel);
            end
          end
          SHOW: begin
            if (slot_end) begin
              state      <= BLANK;
              an_n       <= '1;
              dig_sel    <= sel_inc;
              dig_val    <= digit_of(next_active, sel_inc);
              frame_done <= wrap;
            end
          end
          default: begin
            state <= IDLE;
            an_n  <= '1;
          end
        endcase
      end
    end
  end

endmodule
